vga_scan_timing: RTL
====================

# vga_scan_timing

Generates 640x480@60 Hz VGA raster timing for the game display: pixel strobe, sync pulses, active-video flag, and the current beam coordinates. It feeds the per-pixel layer generators (health, tiles, score) with `x`/`y`, and gives them a once-per-frame `animate` pulse. Layers latch new game data on that pulse so no frame is drawn with half-updated data.

## Interface

Parameters
- `CLK_DIV`, default 4: `clk` cycles per pixel (100 MHz fabric clock gives 25 MHz pixels). Legal range 1..16.

Ports
- `clk`  in  1  system clock; all logic on its rising edge
- `res`  in  1  asynchronous, active-low reset
- `pix_stb`  out  1  one-`clk` pulse each pixel period
- `x`  out  10  horizontal position 0..799, raw
- `y`  out  9  vertical position 0..479; held at 479 during vertical blanking
- `active`  out  1  high when h<640 and v<480
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `animate`  out  1  one-`clk` pulse at the first vertical-blanking pixel
- `frame`  out  16  frame counter (see Configuration)

## Operation

- Internal registers:
  - `div` runs 0..CLK_DIV-1.
  - `h_cnt` (10 b) runs 0..799.
  - `v_cnt` (10 b) runs 0..524.
- Step event: the cycle in which `div == CLK_DIV-1`.
  - `div` returns to 0.
  - `h_cnt` increments. At 799 it wraps to 0 and `v_cnt` increments.
  - `v_cnt` wraps from 524 to 0.
  - Otherwise `div` increments.
- Horizontal timing: 640 visible, 16 front porch, 96 sync, 48 back porch.
  - `hsync` is low for h_cnt 656..751.
- Vertical timing: 480 visible, 10 front porch, 2 sync, 33 back porch.
  - `vsync` is low for v_cnt 490..491.
- All outputs are registered and decoded from the post-step position. They change only on the clock edge that asserts `pix_stb`.
- `animate` is high together with `pix_stb` on the single step whose new position is (h=0, v=480). It is low otherwise.
- `y` is `v_cnt[8:0]` when v_cnt<480, else 479.

## Timing

- Reset (`res` low, asynchronous):
  - Position h=799, v=524, `div`=0.
  - Outputs: `x`=799, `y`=479, `hsync`=1, `vsync`=1, `active`=0, `animate`=0, `pix_stb`=0, `frame`=0.
- First step after release: on the CLK_DIV-th rising edge after `res` goes high. It produces `x`=0, `y`=0, `active`=1 and `pix_stb`=1.
- Periods:
  - Pixel period is CLK_DIV clks.
  - Line period is 800·CLK_DIV clks.
  - Frame period is 420000·CLK_DIV clks.
- `pix_stb` and `animate` are exactly one `clk` wide for every CLK_DIV. When CLK_DIV=1, `pix_stb` is constantly high after reset and `animate` is one clk wide.
- Latency from position change to outputs is 0 extra cycles, since outputs are registered with the counters.
- A reset asserted mid-frame aborts the scan immediately. The sequence restarts exactly as after power-up, and no partial `animate` is produced.
- Wrap at (799,524)→(0,0):
  - `vsync` is already high.
  - `y` goes from 479 (clamped) to 0.
  - `animate` is not asserted.

## Configuration

- `VGA_FRAME_CNT_EN` defined:
  - `frame` increments by 1 on each `animate` pulse, in the same edge.
  - 16-bit wrap from 65535 to 0.
  - Reset value is 0.
- Undefined: `frame` is tied to 0 and no counter logic is synthesized. The port stays present so instantiations do not change.

## Test plan

- Reset and first step, CLK_DIV=4:
  - Hold `res` low, then release.
  - Outputs match the reset values listed above.
  - The first `pix_stb` comes on the 4th edge, with `x`=0, `y`=0, `active`=1.
- Line timing:
  - Consecutive x=0 steps are 3200 clks apart.
  - `hsync` low spans exactly 96 strobes, beginning at x=656.
  - `active` falls at x=640.
- Frame timing:
  - `vsync` low spans exactly 1600 strobes, at v 490..491.
  - `y` reads 479 throughout v 480..524.
  - `active` is 0 in all of those lines.
- Animate:
  - Exactly one pulse per frame, at x=0 during vblank.
  - Consecutive pulses are 1,680,000 clks apart.
  - The pulse coincides with `pix_stb`.
- Mid-frame reset:
  - Pulse `res` low at position (300,200).
  - Outputs return to the reset values asynchronously.
  - The restart timing is identical to the first test.
- CLK_DIV=1 with `VGA_FRAME_CNT_EN` defined:
  - `pix_stb` stays high.
  - `frame` reads 0,1,2,3 after 3 `animate` pulses.
  - With the macro undefined, `frame` stays 0.

Source files
------------

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: 640x480@60 Hz VGA raster timing generator.
// Produces a pixel strobe, active-low sync pulses, the active-video flag,
// beam coordinates and a once-per-frame animate pulse at the start of vblank.
// Optional feature macro: VGA_FRAME_CNT_EN. When it is defined, a 16-bit frame
// counter steps on every animate pulse. Otherwise the frame port is tied to 0.
module vga_scan_timing #(
  parameter int CLK_DIV = 4  // clk cycles per pixel, 1..16
) (
  input  logic        clk,
  input  logic        res,      // asynchronous, active-low
  output logic        pix_stb,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        animate,
  output logic [15:0] frame
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Horizontal: 640 visible, 16 front porch, 96 sync, 48 back porch.
  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_SYNC_LO = 10'd656;
  localparam logic [9:0] H_SYNC_HI = 10'd751;
  localparam logic [9:0] H_LAST    = 10'd799;
  // Vertical: 480 visible, 10 front porch, 2 sync, 33 back porch.
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_SYNC_LO = 10'd490;
  localparam logic [9:0] V_SYNC_HI = 10'd491;
  localparam logic [9:0] V_LAST    = 10'd524;

  logic [DIV_W-1:0] div;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             step;
  logic             animate_nxt;

  // Post-step beam position; every output is decoded from it so the outputs
  // land on the same edge as the counters with no extra latency.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    step        = (div == DIV_LAST);
    h_nxt       = (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
    v_nxt       = v_cnt;
    if (h_cnt == H_LAST) begin
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
    animate_nxt = step && (h_nxt == 10'd0) && (v_nxt == V_VISIBLE);
  end

  // Pixel clock divider: wraps to 0 on the step cycle.
  // NOTE: state registers use non-blocking assignments under an asynchronous
  // reset so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      div <= '0;
    end else if (step) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Beam counters and registered outputs; everything but the strobes only
  // moves on a step. Reset parks the beam at (799,524) so the first step
  // lands on (0,0).
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      h_cnt   <= H_LAST;
      v_cnt   <= V_LAST;
      pix_stb <= 1'b0;
      x       <= H_LAST;
      y       <= 9'd479;
      active  <= 1'b0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      animate <= 1'b0;
    end else begin
      pix_stb <= step;
      animate <= animate_nxt;
      if (step) begin
        h_cnt  <= h_nxt;
        v_cnt  <= v_nxt;
        x      <= h_nxt;
        y      <= (v_nxt < V_VISIBLE) ? v_nxt[8:0] : 9'd479;
        active <= (h_nxt < H_VISIBLE) && (v_nxt < V_VISIBLE);
        hsync  <= !((h_nxt >= H_SYNC_LO) && (h_nxt <= H_SYNC_HI));
        vsync  <= !((v_nxt >= V_SYNC_LO) && (v_nxt <= V_SYNC_HI));
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Frame counter: steps on the same edge that raises animate, wraps at 16 bits.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      frame <= '0;
    end else if (animate_nxt) begin
      frame <= frame + 16'd1;
    end
  end
`else
  assign frame = '0;
`endif

endmodule
